rst_req_ctrl: RTL
=================

Name: rst_req_ctrl

Overview:
Always-on reset-request controller that sits directly upstream of the system reset manager and drives its programming-reset input (prog_rst_ni).
- Merges four reset sources into one registered active-low request with a guaranteed minimum width:
  - external push-button (asynchronous)
  - software reset register pulse
  - watchdog bite
  - boot-programmer activity level
- Keeps a sticky reset-cause register for firmware.
- Clocked and reset only by the always-on clk_i/rst_ni, never by sys_rst_ni.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable synchronized cycles required to accept a button level change (>=2)
STRETCH_CYCLES, 32, minimum low width of prog_rst_no in cycles (>=2)
COOLDOWN_CYCLES, 4, cycles after release during which new requests are latched but not acted on (>=1)

Ports:
clk_i  input  1  system clock, always-on domain
rst_ni  input  1  asynchronous active-low reset (power-on/pad)
btn_rst_ni  input  1  external reset button, asynchronous, active-low
sw_rst_req_i  input  1  single-cycle software reset request
wdog_bite_i  input  1  single-cycle watchdog reset request
boot_prog_active_i  input  1  level; high while the boot loader writes instruction memory
rst_cause_clr_i  input  1  single-cycle clear of the cause register
prog_rst_no  output  1  active-low reset request to the reset manager
rst_cause_o  output  4  sticky cause {3:wdog, 2:sw, 1:btn, 0:prog}
busy_o  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i.
- Reset values:
  - prog_rst_no=1; rst_cause_o=0; busy_o=0; FSM=IDLE
  - counters=0; pending=0; debounced button=released
- Button path:
  - 2-FF synchronizer, sync FFs reset to 1.
  - Debounce counter reloads on any change of the synchronized level.
  - The debounced level updates when the synchronized level has been stable for DEBOUNCE_CYCLES cycles.
  - Press accepted no earlier than 2+DEBOUNCE_CYCLES cycles after the pin falls; glitches shorter than that are ignored.
- Request events:
  - pulse = sw_rst_req_i | wdog_bite_i | button press edge (debounced 1->0) | rising edge of boot_prog_active_i
  - level = debounced button pressed | boot_prog_active_i
- FSM (registered prog_rst_no = 0 in ASSERT and HOLD, 1 otherwise):
  - IDLE: on pulse in cycle N -> ASSERT, counter cleared; prog_rst_no low from cycle N+1.
  - ASSERT: counts STRETCH_CYCLES. At terminal count: level high -> HOLD, else -> COOLDOWN. Further pulses are absorbed; the stretch does not restart.
  - HOLD: stays while level is high. When level drops -> ASSERT with counter cleared, so release is always preceded by a full stretch.
  - COOLDOWN: counts COOLDOWN_CYCLES with prog_rst_no=1. Any pulse here sets pending. At terminal count: pending -> ASSERT (pending cleared), else -> IDLE.
- Cause register:
  - Each source's bit is set in the cycle its pulse is seen, in any state.
  - rst_cause_clr_i clears all bits. If a set and a clear coincide on the same bit, the set wins.
  - Multiple simultaneous sources set multiple bits.
- rst_ni asserted mid-sequence: everything returns to reset values immediately (asynchronous), and the cause register is lost. Power-on is not a recorded cause.
- Counter widths are $clog2(max parameter + 1); no wrap-around is permitted because counters saturate at terminal count.

Optional Feature:
RST_REQ_WDOG_EN
- Defined: wdog_bite_i is a request source and cause bit 3 is live.
- Undefined: wdog_bite_i is ignored, bit 3 is tied to 0, and the port remains present (unconnected internally).

Decomposition:
- Package rst_req_pkg:
  - FSM state enum {IDLE, ASSERT, HOLD, COOLDOWN}
  - cause bit index localparams (CAUSE_PROG=0, CAUSE_BTN=1, CAUSE_SW=2, CAUSE_WDOG=3)
  - cause vector width 4
- Sub-module rst_btn_debounce: synchronizer plus debounce counter. Outputs the debounced level and a press-edge pulse; parameter DEBOUNCE_CYCLES.

Test Plan:
1. sw_rst_req_i pulse at cycle 10 (defaults) -> prog_rst_no low cycles 11..42, high at 43; rst_cause_o=4'b0100; busy_o high until COOLDOWN ends at cycle 47.
2. btn_rst_ni low for 10 cycles, then low for 100 cycles -> first press ignored; second press gives prog_rst_no low about 18 cycles after the fall, held while pressed, plus 32 cycles after the debounced release; cause=4'b0010.
3. boot_prog_active_i high for 200 cycles -> prog_rst_no low throughout, plus 32 cycles after it falls; cause bit 0 set.
4. wdog_bite_i during COOLDOWN -> second ASSERT of 32 cycles starts right after cooldown; both bits set if sw preceded it. With RST_REQ_WDOG_EN undefined, the same stimulus gives no reset and bit 3=0.
5. rst_cause_clr_i in the same cycle as sw_rst_req_i -> bit 2 reads 1, other bits 0.
6. rst_ni asserted mid-ASSERT (cycle 20) -> prog_rst_no=1 and cause=0 immediately; after deassert, IDLE with no residual stretch.

Source files
------------

// File: rtl/rst_req_pkg.sv
// Shared types and constants for the always-on reset-request controller.
// Ports: none (package). Provides the FSM state enum, the cause-bit indices
// and a small helper used to size the shared stretch/cooldown counter.
package rst_req_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    HOLD     = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  localparam int CAUSE_W    = 4;
  localparam int CAUSE_PROG = 0;
  localparam int CAUSE_BTN  = 1;
  localparam int CAUSE_SW   = 2;
  localparam int CAUSE_WDOG = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_req_ctrl_debounce.sv
// Push-button conditioning: 2-FF synchronizer followed by a debounce counter.
// Ports: clk_i/rst_ni (always-on), btn_n (raw async active-low pin),
//        pressed (debounced level, 1 = held down), press (1-cycle pulse on accepted press).
module rst_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_n,
  output logic pressed,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;   // [1] is the synchronized pin level
  logic             level_q;  // debounced pin level, 1 = released
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // The counter only runs while the synchronized level disagrees with the
  // debounced level; any return to agreement reloads it, so a new level is
  // accepted only after DEBOUNCE_CYCLES uninterrupted cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n};
      press_q <= 1'b0;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        press_q <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign pressed = ~level_q;
  assign press   = press_q;

endmodule

// File: rtl/rst_req_ctrl.sv
// Always-on reset-request controller feeding the reset manager's programming
// reset. Merges button, software, watchdog and boot-programmer requests into one
// registered active-low request with a minimum low width, plus a sticky cause register.
// Ports: clk_i/rst_ni (always-on), btn_rst_ni, sw_rst_req_i, wdog_bite_i,
//        boot_prog_active_i, rst_cause_clr_i -> prog_rst_no, rst_cause_o[3:0], busy_o.
// Build option: define RST_REQ_WDOG_EN to make wdog_bite_i a live request source.
module rst_req_ctrl
  import rst_req_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STRETCH_CYCLES  = 32,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               btn_rst_ni,
  input  logic               sw_rst_req_i,
  input  logic               wdog_bite_i,
  input  logic               boot_prog_active_i,
  input  logic               rst_cause_clr_i,
  output logic               prog_rst_no,
  output logic [CAUSE_W-1:0] rst_cause_o,
  output logic               busy_o
);

  localparam int CNT_W = $clog2(max2(STRETCH_CYCLES, COOLDOWN_CYCLES) + 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST    = CNT_W'(COOLDOWN_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic               prog_rst_q, prog_rst_d;
  logic [CAUSE_W-1:0] cause_q, cause_d, cause_set;
  logic               boot_q;

  logic btn_pressed, btn_press;
  logic boot_rise, wdog_req, pulse, level;

  rst_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .btn_n  (btn_rst_ni),
    .pressed(btn_pressed),
    .press  (btn_press)
  );

`ifdef RST_REQ_WDOG_EN
  assign wdog_req = wdog_bite_i;
`else
  logic unused_wdog;
  assign unused_wdog = wdog_bite_i;
  assign wdog_req    = 1'b0;
`endif

  assign boot_rise = boot_prog_active_i & ~boot_q;
  assign pulse     = sw_rst_req_i | wdog_req | btn_press | boot_rise;
  assign level     = btn_pressed | boot_prog_active_i;

  // Cause bits: a set in the same cycle as a clear survives the clear.
  always_comb begin
    cause_set             = '0;
    cause_set[CAUSE_PROG] = boot_rise;
    cause_set[CAUSE_BTN]  = btn_press;
    cause_set[CAUSE_SW]   = sw_rst_req_i;
    cause_set[CAUSE_WDOG] = wdog_req;
    cause_d = (rst_cause_clr_i ? '0 : cause_q) | cause_set;
  end

  // State register (plus the registered outputs that depend on next state).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      prog_rst_q <= 1'b1;
      cause_q    <= '0;
      boot_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      prog_rst_q <= prog_rst_d;
      cause_q    <= cause_d;
      boot_q     <= boot_prog_active_i;
    end
  end

  // Next-state logic. A pulse arriving in the last cooldown cycle is treated
  // like one already pending so it is never dropped on the way back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (pulse) state_d = ASSERT;
      ASSERT:   if (cnt_q == STRETCH_LAST) state_d = level ? HOLD : COOLDOWN;
      HOLD:     if (!level) state_d = ASSERT;
      COOLDOWN: if (cnt_q == COOL_LAST) state_d = (pending_q | pulse) ? ASSERT : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output / datapath control. The counter clears on every state change and
  // only advances while a timed state is kept, which happens strictly below
  // its terminal count, so it can never wrap.
  always_comb begin
    cnt_d      = '0;
    pending_d  = 1'b0;
    prog_rst_d = ~((state_d == ASSERT) | (state_d == HOLD));
    if ((state_d == state_q) && ((state_q == ASSERT) || (state_q == COOLDOWN))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if ((state_q == COOLDOWN) && (state_d == COOLDOWN)) begin
      pending_d = pending_q | pulse;
    end
  end

  assign prog_rst_no = prog_rst_q;
  assign rst_cause_o = cause_q;
  assign busy_o      = (state_q != IDLE);

endmodule
